// File: rtl/psum_tx.sv
// Partial-sum transmitter: streams acc_len signed words into an external
// accumulator, then captures its sum (optionally ReLU'd) as a held result.
module psum_tx #(
    parameter int psum_bw = 16,
    parameter int len_bw  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [len_bw-1:0]  acc_len,
    input  logic               relu_en,
    output logic               busy,
    input  logic               src_valid,
    input  logic [psum_bw-1:0] src_data,
    output logic               src_ready,
    output logic               acc_valid,
    output logic [psum_bw-1:0] acc_data,
    output logic               acc_clr,
    input  logic [psum_bw-1:0] acc_sum,
    output logic               res_valid,
    output logic [psum_bw-1:0] res_data,
    input  logic               res_ready
);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SEND,
        DRAIN,
        CAPT,
        HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [len_bw-1:0]    cnt_q, cnt_d;
    logic                 relu_q, relu_d;
    logic                 busy_q, busy_d;
    logic                 src_ready_q, src_ready_d;
    logic                 acc_valid_q, acc_valid_d;
    logic [psum_bw-1:0]   acc_data_q, acc_data_d;
    logic                 acc_clr_q, acc_clr_d;
    logic                 res_valid_q, res_valid_d;
    logic [psum_bw-1:0]   res_data_q, res_data_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        relu_d      = relu_q;
        acc_valid_d = 1'b0;
        acc_data_d  = acc_data_q;
        res_data_d  = res_data_q;
        unique case (state_q)
            IDLE: begin
                if (start && (acc_len != '0)) begin
                    state_d = CLR;
                    cnt_d   = acc_len;
                    relu_d  = relu_en;
                end
            end
            CLR: state_d = SEND;
            SEND: begin
                if (src_valid && src_ready_q) begin
                    acc_valid_d = 1'b1;
                    acc_data_d  = src_data;
                    cnt_d       = cnt_q - 1'b1;
                    if (cnt_q == len_bw'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: state_d = CAPT;
            CAPT: begin
                res_data_d = (relu_q && acc_sum[psum_bw-1]) ? '0 : acc_sum;
                state_d    = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Status outputs are registered, so derive them from the next state.
        busy_d      = (state_d != IDLE);
        src_ready_d = (state_d == SEND);
        acc_clr_d   = (state_d == CLR);
        res_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            relu_q      <= 1'b0;
            busy_q      <= 1'b0;
            src_ready_q <= 1'b0;
            acc_valid_q <= 1'b0;
            acc_data_q  <= '0;
            acc_clr_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            relu_q      <= relu_d;
            busy_q      <= busy_d;
            src_ready_q <= src_ready_d;
            acc_valid_q <= acc_valid_d;
            acc_data_q  <= acc_data_d;
            acc_clr_q   <= acc_clr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign busy      = busy_q;
    assign src_ready = src_ready_q;
    assign acc_valid = acc_valid_q;
    assign acc_data  = acc_data_q;
    // The accumulator is cleared alongside this block while reset is held.
    assign acc_clr   = acc_clr_q | ~rst;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_psum_tx.sv
// Bench for psum_tx: directed cases plus randomized traffic, checked every
// cycle against a job-level timing model and an arithmetic sum.
module tb_psum_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  acc_len = '0;
    logic        relu_en = 1'b0;
    logic        busy;
    logic        src_valid = 1'b0;
    logic [15:0] src_data = '0;
    logic        src_ready;
    logic        acc_valid;
    logic [15:0] acc_data;
    logic        acc_clr;
    logic [15:0] acc_sum = '0;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] q[$];
    int          vmode = 0;
    bit          tog = 1'b0;
    bit          rand_mode = 1'b0;

    // Model state: job-level timestamps and running arithmetic sum
    bit          m_active = 1'b0;
    int          m_since = 0;
    int          m_left = 0;
    int          m_tail = 0;
    bit          m_relu = 1'b0;
    logic [15:0] m_sum = '0;
    logic [15:0] m_res = '0;
    bit          m_av = 1'b0;
    logic [15:0] m_ad = '0;

    psum_tx #(.psum_bw(16), .len_bw(8)) dut (
        .clk(clk), .rst(rst), .start(start), .acc_len(acc_len),
        .relu_en(relu_en), .busy(busy), .src_valid(src_valid),
        .src_data(src_data), .src_ready(src_ready), .acc_valid(acc_valid),
        .acc_data(acc_data), .acc_clr(acc_clr), .acc_sum(acc_sum),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    // Downstream accumulator the block drives
    always @(posedge clk) begin
        if (acc_clr) acc_sum <= '0;
        else if (acc_valid) acc_sum <= acc_sum + acc_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        bit rdy, bt, hold;
        rdy  = m_active && m_since >= 1 && m_left > 0;
        bt   = rdy && src_valid;
        hold = m_active && m_left == 0 && m_tail >= 2;
        if (!rst) begin
            m_active = 0; m_since = 0; m_left = 0; m_tail = 0; m_relu = 0;
            m_av = 0; m_ad = '0; m_res = '0; m_sum = '0;
        end else begin
            m_av = bt;
            if (m_active) begin
                m_since++;
                if (bt) begin
                    m_ad  = src_data;
                    m_sum = m_sum + src_data;
                    m_left--;
                    if (m_left == 0) m_tail = 0;
                    if (q.size() > 0) void'(q.pop_front());
                end else if (m_left == 0) begin
                    if (m_tail == 1) m_res = (m_relu && m_sum[15]) ? 16'h0 : m_sum;
                    if (hold && res_ready) m_active = 0;
                    m_tail++;
                end
            end else if (start && acc_len != 0) begin
                m_active = 1; m_since = 0; m_left = int'(acc_len); m_tail = 0;
                m_relu = relu_en; m_sum = '0;
            end
        end
        #1;
        chk("busy", 32'(busy), 32'(m_active));
        chk("src_ready", 32'(src_ready), 32'(m_active && m_since >= 1 && m_left > 0));
        chk("acc_clr", 32'(acc_clr), 32'(!rst || (m_active && m_since == 0)));
        chk("acc_valid", 32'(acc_valid), 32'(m_av));
        chk("acc_data", 32'(acc_data), 32'(m_ad));
        chk("res_valid", 32'(res_valid), 32'(m_active && m_left == 0 && m_tail >= 2));
        chk("res_data", 32'(res_data), 32'(m_res));
    end

    always @(negedge clk) begin
        if (rand_mode) begin
            rst       = ($urandom_range(399) != 0);
            start     = ($urandom_range(3) == 0);
            acc_len   = 8'($urandom_range(7));
            relu_en   = 1'($urandom_range(1));
            res_ready = 1'($urandom_range(1));
        end
        if (q.size() > 0) begin
            src_data = q[0];
            case (vmode)
                0: src_valid = 1'b1;
                1: begin tog = !tog; src_valid = tog; end
                default: src_valid = 1'($urandom_range(1));
            endcase
        end else if (rand_mode) begin
            src_valid = ($urandom_range(2) != 0);
            src_data  = 16'($urandom);
        end else begin
            src_valid = 1'b0;
        end
    end

    task automatic start_job(input int len, input bit relu);
        @(negedge clk);
        start = 1'b1; acc_len = 8'(len); relu_en = relu;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    // Cycle numbering: the cycle in which start is sampled is cycle 0.
    task automatic wait_res(input bit stray, output logic [15:0] val,
                            output int rcyc, output longint mask);
        int k;
        k = 1; mask = 0; rcyc = -1; val = '0;
        while (k < 400) begin
            if (stray && k == 3) begin start = 1'b1; acc_len = 8'd5; relu_en = 1'b1; end
            if (stray && k == 4) start = 1'b0;
            if (acc_valid && k < 64) mask = mask | (64'(1) << k);
            if (res_valid) begin rcyc = k; val = res_data; break; end
            @(posedge clk); #2;
            k++;
        end
        if (rcyc < 0) chk("res_timeout", 32'(0), 32'(1));
    endtask

    task automatic consume(input int n, input bit stray, input logic [15:0] val);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
            start = (stray && i == 3);
            if (stray && i == 3) begin acc_len = 8'd5; relu_en = 1'b1; end
            chk("hold_valid", 32'(res_valid), 32'(1));
            chk("hold_data", 32'(res_data), 32'(val));
        end
        start = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #2;
        res_ready = 1'b0;
        chk("done_valid", 32'(res_valid), 32'(0));
        chk("done_busy", 32'(busy), 32'(0));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [15:0] v;
        int          rc;
        longint      mk;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_clr", 32'(acc_clr), 32'(1));
        chk("rst_res", 32'(res_data), 32'(0));
        chk("rst_accd", 32'(acc_data), 32'(0));
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);

        // 5,-2,7 back-to-back
        vmode = 0;
        q = '{16'd5, 16'hFFFE, 16'd7};
        start_job(3, 0);
        wait_res(0, v, rc, mk);
        chk("t1_cycle", 32'(rc), 32'(7));
        chk("t1_mask", mk[31:0], 32'h38);
        chk("t1_data", 32'(v), 32'd10);
        consume(0, 0, v);

        // -4,-3 with and without ReLU
        q = '{16'hFFFC, 16'hFFFD};
        start_job(2, 1);
        wait_res(0, v, rc, mk);
        chk("t2_relu", 32'(v), 32'h0);
        consume(0, 0, v);
        q = '{16'hFFFC, 16'hFFFD};
        start_job(2, 0);
        wait_res(0, v, rc, mk);
        chk("t2_norelu", 32'(v), 32'hFFF9);
        consume(0, 0, v);

        // Bubbles every other cycle
        vmode = 1;
        q = '{16'd1, 16'd2, 16'd3, 16'd4};
        start_job(4, 0);
        wait_res(0, v, rc, mk);
        chk("t3_beats", 32'($countones(mk)), 32'd4);
        chk("t3_data", 32'(v), 32'd10);
        consume(0, 0, v);
        vmode = 0;

        // Stray starts in SEND and HOLD, long HOLD, zero-length start
        q = '{16'hFFFD, 16'd1};
        start_job(2, 0);
        wait_res(1, v, rc, mk);
        chk("t4_data", 32'(v), 32'hFFFE);
        consume(10, 1, v);
        start_job(0, 0);
        chk("t4_zero_busy", 32'(busy), 32'(0));
        repeat (3) @(posedge clk);
        #2 chk("t4_zero_busy2", 32'(busy), 32'(0));

        // Wraparound
        q = '{16'h7FFF, 16'h0001};
        start_job(2, 0);
        wait_res(0, v, rc, mk);
        chk("t5_wrap", 32'(v), 32'h8000);
        consume(0, 0, v);
        q = '{16'h7FFF, 16'h0001};
        start_job(2, 1);
        wait_res(0, v, rc, mk);
        chk("t5_wrap_relu", 32'(v), 32'h0);
        consume(0, 0, v);

        // Reset during SEND after the first beat
        q = '{16'd4, 16'd5, 16'd6};
        start_job(3, 0);
        for (int i = 0; i < 10 && !acc_valid; i++) begin
            @(posedge clk); #2;
        end
        chk("t6_beat_seen", 32'(acc_valid), 32'(1));
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #2;
        chk("t6_clr", 32'(acc_clr), 32'(1));
        chk("t6_busy", 32'(busy), 32'(0));
        chk("t6_accv", 32'(acc_valid), 32'(0));
        chk("t6_accd", 32'(acc_data), 32'(0));
        chk("t6_resd", 32'(res_data), 32'(0));
        q.delete();
        @(negedge clk) rst = 1'b1;
        repeat (4) @(posedge clk);
        q = '{16'd9};
        start_job(1, 0);
        wait_res(0, v, rc, mk);
        chk("t6_data", 32'(v), 32'd9);
        consume(0, 0, v);

        // Maximum length
        for (int i = 0; i < 255; i++) q.push_back(16'd1);
        start_job(255, 0);
        wait_res(0, v, rc, mk);
        chk("t7_cycle", 32'(rc), 32'(259));
        chk("t7_data", 32'(v), 32'd255);
        consume(0, 0, v);

        // Randomized traffic
        @(negedge clk) rand_mode = 1'b1;
        repeat (4000) @(posedge clk);
        @(negedge clk);
        rand_mode = 1'b0;
        rst = 1'b1; start = 1'b0; res_ready = 1'b1;
        repeat (30) @(posedge clk);
        #2 chk("end_idle", 32'(busy), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/psum_tx.md
PSUM_TX -- requirements
Module: psum_tx

Interface
REQ-001 Parameter psum_bw, default 16, width of partial-sum words and result.
REQ-002 Parameter len_bw, default 8, width of the beat-count input.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-005 start  input  1  job request; sampled only in IDLE.
REQ-006 acc_len  input  len_bw  beats per job, unsigned; latched on accepted start.
REQ-007 relu_en  input  1  apply ReLU to the result; latched on accepted start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 src_valid  input  1  upstream partial-sum word available.
REQ-010 src_data  input  psum_bw  upstream partial-sum word, signed.
REQ-011 src_ready  output  1  block accepts a word this cycle.
REQ-012 acc_valid  output  1  drives the downstream accumulator's in_valid.
REQ-013 acc_data  output  psum_bw  drives the downstream accumulator's in, signed.
REQ-014 acc_clr  output  1  active-high clear to the downstream accumulator's rst.
REQ-015 acc_sum  input  psum_bw  downstream accumulator's out, signed.
REQ-016 res_valid  output  1  result available.
REQ-017 res_data  output  psum_bw  result word, signed.
REQ-018 res_ready  input  1  consumer accepts the result.

Function
REQ-019 The FSM SHALL have states IDLE, CLR, SEND, DRAIN, CAPT, HOLD.
REQ-020 IDLE: start=1 and acc_len!=0 -> CLR, latching acc_len into a beat counter and relu_en; start with acc_len==0 is ignored (stay IDLE).
REQ-021 CLR: acc_clr=1 for exactly one cycle -> SEND.
REQ-022 SEND: src_ready=1; a beat is accepted when src_valid && src_ready; each accepted beat decrements the counter; the last beat -> DRAIN; src_valid low holds SEND with no beat accepted.
REQ-023 acc_valid/acc_data SHALL be registered: acc_valid=1 and acc_data=src_data in the cycle after each accepted beat, otherwise acc_valid=0 and acc_data holds its last value.
REQ-024 DRAIN: one cycle (carries acc_valid for the last beat) -> CAPT.
REQ-025 CAPT: one cycle; at its end res_data <= (latched relu_en && acc_sum[psum_bw-1]) ? 0 : acc_sum -> HOLD.
REQ-026 HOLD: res_valid=1, res_data stable; res_valid && res_ready -> IDLE (res_valid=0 next cycle).
REQ-027 src_ready SHALL be 0 outside SEND; acc_clr SHALL be 0 outside CLR and reset.
REQ-028 start in any state other than IDLE SHALL be ignored and SHALL NOT alter latched acc_len/relu_en.
REQ-029 No saturation: sums wrap modulo 2^psum_bw as produced by the accumulator; the block passes acc_sum unmodified except for ReLU.
REQ-030 Latency with src_valid held high: start sampled in cycle 0 -> CLR cycle 1, beats accepted cycles 2..acc_len+1, res_valid=1 from cycle acc_len+4.
REQ-031 acc_len = 2^len_bw-1 SHALL be supported without counter wrap.

Reset
REQ-032 rst=0 at a rising edge SHALL force IDLE, busy=0, src_ready=0, acc_valid=0, acc_data=0, res_valid=0, res_data=0, beat counter=0, latched relu_en=0.
REQ-033 acc_clr SHALL be 1 combinationally while rst=0, clearing the accumulator together with this block.
REQ-034 Reset mid-job (any state) SHALL abandon the job; no res_valid pulse for it; first cycle after release is IDLE.

Verification
REQ-035 acc_len=3, relu_en=0, src_data 5,-2,7 back-to-back -> acc_valid cycles 3,4,5; res_valid cycle 7, res_data=10.
REQ-036 acc_len=2, relu_en=1, src_data -4,-3 -> res_data=0; same with relu_en=0 -> res_data=-7 (0xFFF9).
REQ-037 acc_len=4 with src_valid low every other cycle -> exactly 4 acc_valid pulses, res_data=sum, beat count never skipped.
REQ-038 res_ready held low 10 cycles in HOLD -> res_valid/res_data stable; start pulses during job and HOLD ignored; start with acc_len=0 -> busy stays 0.
REQ-039 acc_len=2, src_data 0x7FFF,0x0001 -> res_data=0x8000 (wrap), relu_en=1 -> 0.
REQ-040 rst=0 asserted during SEND after 1 beat -> next cycle IDLE, acc_clr=1 during reset, all outputs zero; following job acc_len=1, data 9 -> res_data=9.
